// File: rtl/nco_voice_pkg.sv
// Shared definitions for the single-voice NCO tone generator.
//   - wave_sel encodings
//   - envelope state enum
//   - power-on frequency table (phase increments tuned for a 41.7 kHz sample rate)
package nco_voice_pkg;

  localparam logic [1:0] WAVE_RAMP   = 2'd0;
  localparam logic [1:0] WAVE_SINE   = 2'd1;
  localparam logic [1:0] WAVE_SQUARE = 2'd2;
  localparam logic [1:0] WAVE_TRI    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  // Default table entry for note code idx. Entry 0 stays 0 so note 0 is silent.
  function automatic logic [31:0] def_freq(input int idx);
    case (idx)
      1:       return 32'd103079215;
      2:       return 32'd83079215;
      3:       return 32'd32979215;
      4:       return 32'd19979215;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/nco_voice_env.sv
// Linear attack/release envelope with saturating up/down counter.
//   clk, rst : clock, synchronous active-high reset
//   ena      : sample-rate enable; the FSM moves only on ena
//   note_on  : a nonzero note is held
//   env      : envelope level
//   state    : envelope state
// A state change caused by note_on (IDLE->ATTACK, ATTACK/SUSTAIN->RELEASE,
// RELEASE->ATTACK) holds env for that sample; env moves only while already
// in ATTACK or RELEASE. Saturation and the matching state change happen on
// the same ena.
module nco_voice_env
  import nco_voice_pkg::*;
#(
  parameter int ENV_W        = 8,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             note_on,
  output logic [ENV_W-1:0] env,
  output env_state_t       state
);

  localparam logic [ENV_W:0] ENV_MAX = {1'b0, {ENV_W{1'b1}}};
  localparam logic [ENV_W:0] A_STEP  = (ENV_W+1)'(ATTACK_STEP);
  localparam logic [ENV_W:0] R_STEP  = (ENV_W+1)'(RELEASE_STEP);

  logic [ENV_W:0] up;
  assign up = {1'b0, env} + A_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      env   <= '0;
      state <= IDLE;
    end else if (ena) begin
      case (state)
        IDLE: begin
          env <= '0;
          if (note_on) state <= ATTACK;
        end
        ATTACK: begin
          if (!note_on) state <= RELEASE;
          else if (up >= ENV_MAX) begin
            env   <= ENV_MAX[ENV_W-1:0];
            state <= SUSTAIN;
          end else env <= up[ENV_W-1:0];
        end
        SUSTAIN: if (!note_on) state <= RELEASE;
        RELEASE: begin
          if (note_on) state <= ATTACK;    // retrigger from current level
          else if ({1'b0, env} <= R_STEP) begin
            env   <= '0;
            state <= IDLE;
          end else env <= env - R_STEP[ENV_W-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sine_lut14.sv
// Shared sine lookup: 12-bit phase in, 14-bit signed sine out, one clk latency.
//   clk, rst : clock, synchronous active-high reset
//   addr     : phase, full circle = 4096
//   sin      : registered round(sin * 8192), clamped to +/-8191
// Each half-wave uses the parabola 4x(1-x) with the y' = y - 0.225*(y - y^2)
// refinement, which keeps the error within a few LSB without a ROM.
module sine_lut14 (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        addr,
  output logic signed [13:0] sin
);

  logic [10:0] p;
  logic [11:0] q;
  logic [20:0] par;
  logic [13:0] y0, sq, d, corr_s, y1;
  logic [27:0] sq_full;
  logic [22:0] corr;
  logic [12:0] mag;

  always_comb begin
    p       = addr[10:0];
    q       = 12'd2048 - {1'b0, p};
    par     = {10'd0, p} * {9'd0, q};
    y0      = 14'(par >> 7);              // Q13, 8192 = 1.0
    sq_full = {14'd0, y0} * {14'd0, y0};
    sq      = 14'(sq_full >> 13);
    d       = y0 - sq;
    corr    = {9'd0, d} * 23'd461;        // 461/2048 ~ 0.225
    corr_s  = 14'(corr >> 11);
    y1      = y0 - corr_s;
    mag     = (y1 > 14'd8191) ? 13'd8191 : y1[12:0];
  end

  always_ff @(posedge clk) begin
    if (rst) sin <= '0;
    else     sin <= addr[11] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

// File: rtl/nco_voice_gen.sv
// Single-voice tone generator: programmable frequency table, phase accumulator,
// four waveforms and envelope scaling, updated once per sample-rate enable.
//   clk, rst          : clock, synchronous active-high reset
//   ena               : sample-rate enable pulse (>= 2 clk apart)
//   note              : note code, 0 = silence/release
//   wave_sel          : 0 ramp, 1 sine, 2 square, 3 triangle
//   freq_wr/addr/data : frequency table write port
//   l_data, r_data    : signed samples (identical), one sample of latency
//   env_level         : envelope level
//   active            : envelope not IDLE
module nco_voice_gen
  import nco_voice_pkg::*;
#(
  parameter int PHASE_W      = 32,
  parameter int OUT_W        = 24,
  parameter int NOTE_W       = 3,
  parameter int ENV_W        = 8,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [NOTE_W-1:0]       note,
  input  logic [1:0]              wave_sel,
  input  logic                    freq_wr,
  input  logic [NOTE_W-1:0]       freq_addr,
  input  logic [PHASE_W-1:0]      freq_data,
  output logic signed [OUT_W-1:0] l_data,
  output logic signed [OUT_W-1:0] r_data,
  output logic [ENV_W-1:0]        env_level,
  output logic                    active
);

  localparam int NUM_NOTES = 2**NOTE_W;
  localparam int PW        = OUT_W + ENV_W + 1;
  localparam logic signed [OUT_W-1:0] W_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] W_NEG = -W_POS;

  logic [PHASE_W-1:0]      tbl [NUM_NOTES];
  logic [PHASE_W-1:0]      freq, phase;
  logic signed [13:0]      sin_q;
  logic signed [OUT_W-1:0] sin_ext, w, y;
  logic [OUT_W-1:0]        u, t;
  logic signed [PW-1:0]    prod;
  env_state_t              state;

  // Table write and freq read share the edge: freq sees a write one clk later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NOTES; i++) tbl[i] <= PHASE_W'(def_freq(i));
      freq <= '0;
    end else begin
      if (freq_wr) tbl[freq_addr] <= freq_data;
      freq <= tbl[note];
    end
  end

  sine_lut14 u_sine (
    .clk  (clk),
    .rst  (rst),
    .addr (phase[PHASE_W-1 -: 12]),
    .sin  (sin_q)
  );

  nco_voice_env #(
    .ENV_W        (ENV_W),
    .ATTACK_STEP  (ATTACK_STEP),
    .RELEASE_STEP (RELEASE_STEP)
  ) u_env (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .note_on (|note),
    .env     (env_level),
    .state   (state)
  );

  assign active = (state != IDLE);

  // Shaper works on the pre-ena phase/env, so the sample lags by one ena.
  always_comb begin
    sin_ext = OUT_W'(sin_q);
    u       = phase[PHASE_W-2 -: OUT_W];
    t       = phase[PHASE_W-1] ? ~u : u;
    case (wave_sel)
      WAVE_RAMP:   w = phase[PHASE_W-1 -: OUT_W];
      WAVE_SINE:   w = sin_ext <<< (OUT_W - 14);
      WAVE_SQUARE: w = phase[PHASE_W-1] ? W_NEG : W_POS;
      default:     w = {~t[OUT_W-1], t[OUT_W-2:0]};
    endcase
    prod = PW'(w) * PW'($signed({1'b0, env_level}));
    y    = OUT_W'(prod >>> ENV_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= '0;
      l_data <= '0;
      r_data <= '0;
    end else if (ena) begin
      phase  <= phase + freq;
      l_data <= y;
      r_data <= y;
    end
  end

endmodule

// File: doc/nco_voice_gen.md
Name: nco_voice_gen

Overview:
- Single-voice audio tone generator, successor to the fixed-table NCO tone block.
- Adds a runtime-programmable frequency table, four selectable waveforms and a linear attack/release envelope.
- Sits between the note/keypad decoder and the audio codec serializer, and runs once per codec sample-rate enable.
- Drives signed stereo samples, an envelope level and a voice-active flag.

Parameters:
PHASE_W, 32, phase accumulator and frequency word width
OUT_W, 24, audio sample width (signed); must be >= 14 and <= PHASE_W-1
NOTE_W, 3, note code width; table depth NUM_NOTES = 2**NOTE_W
ENV_W, 8, envelope level width (unsigned)
ATTACK_STEP, 4, envelope increment per ena in ATTACK
RELEASE_STEP, 2, envelope decrement per ena in RELEASE

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ena  in  1  sample-rate enable, single-clk pulse, pulses >= 2 clk apart
note  in  NOTE_W  note code; 0 = silence/release
wave_sel  in  2  0 ramp, 1 sine, 2 square, 3 triangle
freq_wr  in  1  table write strobe
freq_addr  in  NOTE_W  table write index
freq_data  in  PHASE_W  table write data (phase increment)
l_data  out  OUT_W  signed left sample
r_data  out  OUT_W  signed right sample (equal to l_data)
env_level  out  ENV_W  current envelope level
active  out  1  high when the envelope state is not IDLE

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset: phase=0, freq=0, env=0, state=IDLE, l_data=r_data=0, active=0, table reloaded from package defaults (entry 0 = 0).
- Table: NUM_NOTES x PHASE_W registers. freq_wr writes entry freq_addr at the clk edge. Entry 0 is writable.
- freq register: every clk, freq <= table[note], reading the table after any same-cycle write. So a write to the selected entry reaches freq 2 clk after the strobe, and a note change reaches freq 1 clk later. freq is sampled without regard to ena.
- NCO: on ena, phase <= phase + freq, mod 2**PHASE_W with silent wrap. Phase is never cleared except by rst, so note changes are phase-continuous.
- Sine: the shared sine lookup takes phase[PHASE_W-1 -: 12], returns 14-bit signed, 1-clk latency. The ena spacing rule guarantees a settled value at the next ena.
- Waveform w (OUT_W signed), computed from the current phase register:
  - ramp: phase[PHASE_W-1 -: OUT_W] as signed.
  - sine: {sin, (OUT_W-14) zeros}.
  - square: MSB=0 -> +(2**(OUT_W-1)-1), MSB=1 -> -(2**(OUT_W-1)-1).
  - triangle: u = phase[PHASE_W-2 -: OUT_W]; t = MSB ? ~u : u; w = t with its top bit inverted.
- Scaling: y = (w * env) >>> ENV_W, arithmetic shift, truncated toward -inf. Full scale is (2**ENV_W-1)/2**ENV_W.
- Output: on ena, l_data, r_data <= y, using the phase and env values held before that ena. Output latency is 1 sample. Outputs hold between ena pulses.
- Envelope FSM (advances only on ena):
  - IDLE: env=0. note!=0 -> ATTACK.
  - ATTACK: env += ATTACK_STEP, saturating at 2**ENV_W-1, then -> SUSTAIN. note==0 -> RELEASE (checked first).
  - SUSTAIN: env held. note==0 -> RELEASE.
  - RELEASE: env -= RELEASE_STEP, saturating at 0, then -> IDLE. note!=0 -> ATTACK from the current env (retrigger, no reset to 0).
- Note change between two nonzero codes in ATTACK or SUSTAIN: legato. Only freq changes; state is unchanged.
- wave_sel is sampled at each ena; switching takes effect on that sample with no glitch filtering.
- rst asserted mid-note: all state returns to reset values on that edge. Any table writes are lost.
- ena=0 indefinitely: phase, env, state and outputs are frozen. Table writes still occur.

Decomposition:
- Package nco_voice_pkg holds:
  - wave_sel encodings (WAVE_RAMP=0, WAVE_SINE=1, WAVE_SQUARE=2, WAVE_TRI=3).
  - Envelope state enum (IDLE, ATTACK, SUSTAIN, RELEASE).
  - Default frequency table constants for 41.7 kHz: 0, 103079215, 83079215, 32979215, 19979215, others 0.
- One sub-module, nco_voice_env: the envelope FSM with saturating up/down counter. Inputs: clk, rst, ena, note_on. Outputs: env, state.
- The existing sine lookup is instantiated directly. Table, NCO and shaper stay in the top module.

Test Plan:
1. Reset, then ena pulses with note=0 -> l_data=r_data=0, active=0, env_level=0, phase stays 0.
2. note=1, wave_sel=ramp, ATTACK_STEP=4 -> env_level 4, 8, 12 on successive ena. Reaches 255 and SUSTAIN after 64 ena. phase advances by 103079215 per ena. l_data = (phase_prev[31:8] * env_prev) >>> 8.
3. Sustained note, then note=0 -> RELEASE, env drops by 2 per ena to 0. active falls on the ena where env hits 0. Retrigger at env=100 -> ATTACK resumes from 100.
4. freq_wr addr=5 data=32'h0100_0000 while note=5 -> freq updates 2 clk after the strobe. Phase MSB toggles every 128 ena. Square output toggles between +8388607 and -8388607 scaled by env.
5. Triangle at env=255 -> phase 0 gives w=-8388608, phase 0x7FFFFFFF gives w=+8388607. Check monotonic rise, then fall, over a full period.
6. rst mid-SUSTAIN after a table write to entry 2 -> all outputs 0 next clk. Table entry 2 reads the default 83079215 (checked by selecting note=2 and measuring phase step).
